aes_round_scheduler: RTL and testbench
======================================

// Module: aes_round_scheduler
// PURPOSE
//   Sequences one shared iterative AES-128 round datapath between two requesters
//   (encrypt port, decrypt port). Arbitrates, issues per-round control and key index
//   to the datapath and key store, returns completion through a valid/ready response.
//   Sits between the host-side request logic and the round datapath/KeyExpansion.
// PARAMETERS
//   NR      10  rounds per block (legal 1..15; elaboration error otherwise)
//   KIDX_W  4   width of round/key index outputs (must hold NR)
// PORTS
//   clk           in   1       clock, rising edge
//   reset         in   1       reset, asynchronous, active-high
//   enc_valid     in   1       encrypt request pending
//   enc_ready     out  1       encrypt request accepted this cycle
//   dec_valid     in   1       decrypt request pending
//   dec_ready     out  1       decrypt request accepted this cycle
//   dp_load       out  1       datapath captures input ^ key[dp_key_idx]
//   dp_round_en   out  1       datapath performs one round this cycle
//   dp_mode       out  1       0 = encrypt, 1 = decrypt (valid while busy)
//   dp_last       out  1       final round: skip (Inv)MixColumns
//   dp_round_idx  out  KIDX_W  current round number 1..NR (0 when idle/load)
//   dp_key_idx    out  KIDX_W  round-key index into expanded key
//   rsp_valid     out  1       datapath result valid
//   rsp_ready     in   1       consumer takes result
//   rsp_src       out  1       0 = enc requester, 1 = dec requester
//   busy          out  1       high in any state except IDLE
// BEHAVIOUR
//   - Reset: all outputs 0, FSM -> IDLE, round counter 0, arbitration pointer -> enc.
//     Reset mid-operation abandons the block; no response issued.
//   - FSM states: IDLE, ROUND, DONE.
//     IDLE: winner's *_ready = valid & grant (combinational); on accept, dp_load=1,
//       dp_key_idx = 0 (enc) or NR (dec); latch mode/src; -> ROUND, counter = 1.
//     ROUND: dp_round_en=1, dp_round_idx=counter, dp_key_idx = counter (enc) or
//       NR-counter (dec), dp_last=(counter==NR); counter==NR -> DONE, else counter+1.
//     DONE: rsp_valid=1, rsp_src stable; on rsp_valid & rsp_ready -> IDLE.
//   - Latency: accept in cycle T -> rounds T+1..T+NR -> rsp_valid from T+NR+1.
//   - No requester ready outside IDLE; throughput 1 block per NR+2 cycles minimum
//     with rsp_ready tied high. DONE holds indefinitely under back-pressure.
//   - Requesters may drop valid before ready without effect; no request is queued.
//   - All dp_* outputs 0 when not driven by the rules above (incl. DONE).
//   - Counter arithmetic unsigned KIDX_W bits; never wraps (bounded by NR).
// CONFIGURATION
//   AES_SCHED_RR_EN defined: round-robin; pointer moves to the other requester
//     after every accept; simultaneous valid -> pointed requester wins.
//   Not defined: fixed priority, dec beats enc on simultaneous valid; no pointer.
// STRUCTURE
//   Package aes_sched_pkg: state enum (IDLE/ROUND/DONE), SRC_ENC=0/SRC_DEC=1,
//     MODE_ENC/MODE_DEC constants, default NR.
//   Sub-module aes_sched_arb: 2-way arbiter (valid pair, accept strobe -> grant
//     pair), holds the round-robin pointer under AES_SCHED_RR_EN.
// TESTING
//   1 enc_valid=1 alone, rsp_ready=1 -> enc_ready at T, dp_key_idx 0,1..10,
//     dp_last only at round 10, rsp_valid at T+11, rsp_src=0.
//   2 dec_valid alone -> dp_mode=1, dp_key_idx 10,9..0 over load+rounds, rsp_src=1.
//   3 enc+dec valid together, repeated: RR_EN -> grants alternate enc/dec starting
//     enc after reset; no RR_EN -> dec wins every time.
//   4 rsp_ready=0 for 20 cycles in DONE -> rsp_valid/rsp_src stable, no *_ready,
//     dp_* all 0; raise rsp_ready -> IDLE next cycle, new accept possible.
//   5 reset asserted at round 5 (async, mid-cycle) -> outputs 0 immediately,
//     no rsp_valid afterwards, next request runs full 10 rounds.
//   6 NR=14 build -> rsp_valid at T+15, dec key sequence 14..0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES-128 round scheduler.
package aes_sched_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } schedState_t;

   localparam logic SRC_ENC  = 1'b0;
   localparam logic SRC_DEC  = 1'b1;
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   localparam int NR_DEFAULT     = 10;
   localparam int KIDX_W_DEFAULT = 4;
endpackage

// File: rtl/aes_sched_arb.sv
// 2-way enc/dec arbiter. AES_SCHED_RR_EN selects round-robin, otherwise
// fixed priority with dec winning ties.
module aes_sched_arb
   import aes_sched_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic encValid,
   input  logic decValid,
   input  logic accept,
   output logic grantEnc,
   output logic grantDec
);

`ifdef AES_SCHED_RR_EN
   logic ptrDec;

   always_comb begin
      grantEnc = encValid & (~decValid | ~ptrDec);
      grantDec = decValid & (~encValid | ptrDec);
   end

   // After an accept the pointer moves away from whoever just won.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       ptrDec <= SRC_ENC;
      else if (accept) ptrDec <= ~grantDec;
   end
`else
   logic unusedArb;

   assign grantDec  = decValid;
   assign grantEnc  = encValid & ~decValid;
   assign unusedArb = clk ^ reset ^ accept;
`endif

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences one shared iterative AES-128 round datapath between an encrypt and a
// decrypt requester. Optional round-robin arbitration via AES_SCHED_RR_EN.
module aes_round_scheduler
   import aes_sched_pkg::*;
#(
   parameter int NR     = NR_DEFAULT,
   parameter int KIDX_W = KIDX_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enc_valid,
   output logic              enc_ready,
   input  logic              dec_valid,
   output logic              dec_ready,
   output logic              dp_load,
   output logic              dp_round_en,
   output logic              dp_mode,
   output logic              dp_last,
   output logic [KIDX_W-1:0] dp_round_idx,
   output logic [KIDX_W-1:0] dp_key_idx,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_src,
   output logic              busy
);

   generate
      if (NR < 1 || NR > 15 || NR >= (1 << KIDX_W)) begin : gBadParam
         $error("aes_round_scheduler: NR must be 1..15 and fit in KIDX_W bits");
      end
   endgenerate

   localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

   schedState_t       state, stateNxt;
   logic [KIDX_W-1:0] count, countNxt;
   logic              modeQ, srcQ;
   logic              grantEnc, grantDec, accept, idleLive;

   aes_sched_arb uArb (
      .clk      (clk),
      .reset    (reset),
      .encValid (enc_valid),
      .decValid (dec_valid),
      .accept   (accept),
      .grantEnc (grantEnc),
      .grantDec (grantDec)
   );

   // Readies are combinational from valid; gate with reset so nothing leaks out
   // while reset is held.
   assign idleLive  = (state == IDLE) & ~reset;
   assign enc_ready = idleLive & enc_valid & grantEnc;
   assign dec_ready = idleLive & dec_valid & grantDec;
   assign accept    = enc_ready | dec_ready;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         modeQ <= MODE_ENC;
         srcQ  <= SRC_ENC;
      end else begin
         state <= stateNxt;
         count <= countNxt;
         if (accept) begin
            modeQ <= dec_ready ? MODE_DEC : MODE_ENC;
            srcQ  <= dec_ready ? SRC_DEC : SRC_ENC;
         end
      end
   end

   always_comb begin
      stateNxt     = state;
      countNxt     = count;
      dp_load      = 1'b0;
      dp_round_en  = 1'b0;
      dp_mode      = 1'b0;
      dp_last      = 1'b0;
      dp_round_idx = '0;
      dp_key_idx   = '0;
      rsp_valid    = 1'b0;
      rsp_src      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               dp_load    = 1'b1;
               dp_key_idx = dec_ready ? NR_K : '0;
               stateNxt   = ROUND;
               countNxt   = ONE_K;
            end
         end
         ROUND: begin
            dp_round_en  = 1'b1;
            dp_mode      = modeQ;
            dp_round_idx = count;
            // Decrypt walks the expanded key backwards, ending on key 0.
            dp_key_idx   = (modeQ == MODE_DEC) ? (NR_K - count) : count;
            dp_last      = (count == NR_K);
            if (count == NR_K) stateNxt = DONE;
            else               countNxt = count + ONE_K;
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_src   = srcQ;
            if (rsp_ready) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler (NR=10 main instance, NR=14 side instance).
module tb_aes_round_scheduler;
   import aes_sched_pkg::*;

   localparam int NR  = 10;
   localparam int NRB = 14;

   logic clk = 1'b0;
   logic reset;
   logic enc_valid, dec_valid, rsp_ready;
   logic enc_ready, dec_ready, dp_load, dp_round_en, dp_mode, dp_last;
   logic [3:0] dp_round_idx, dp_key_idx;
   logic rsp_valid, rsp_src, busy;

   logic bEncValid, bDecValid, bRspReady;
   logic bEncReady, bDecReady, bLoad, bRoundEn, bMode, bLast;
   logic [3:0] bRoundIdx, bKeyIdx;
   logic bRspValid, bRspSrc, bBusy;

   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   aes_round_scheduler #(.NR(NR), .KIDX_W(4)) dut (
      .clk(clk), .reset(reset),
      .enc_valid(enc_valid), .enc_ready(enc_ready),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_mode(dp_mode),
      .dp_last(dp_last), .dp_round_idx(dp_round_idx), .dp_key_idx(dp_key_idx),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .busy(busy)
   );

   aes_round_scheduler #(.NR(NRB), .KIDX_W(4)) dut14 (
      .clk(clk), .reset(reset),
      .enc_valid(bEncValid), .enc_ready(bEncReady),
      .dec_valid(bDecValid), .dec_ready(bDecReady),
      .dp_load(bLoad), .dp_round_en(bRoundEn), .dp_mode(bMode),
      .dp_last(bLast), .dp_round_idx(bRoundIdx), .dp_key_idx(bKeyIdx),
      .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_src(bRspSrc), .busy(bBusy)
   );

   wire [11:0] dpAll = {dp_load, dp_round_en, dp_mode, dp_last, dp_round_idx, dp_key_idx};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One full block on the NR=10 instance; hold>0 keeps rsp_ready low in DONE.
   task automatic doBlock(input string tag, input logic ev, input logic dv,
                          input logic expSrc, input int hold);
      @(negedge clk);
      enc_valid = ev; dec_valid = dv; rsp_ready = (hold == 0);
      #1;
      chk({tag, " encRdy"}, enc_ready, !expSrc);
      chk({tag, " decRdy"}, dec_ready, expSrc);
      chk({tag, " load"}, dp_load, 1);
      chk({tag, " loadKey"}, dp_key_idx, expSrc ? NR : 0);
      chk({tag, " idleBusy"}, busy, 0);
      @(negedge clk);
      enc_valid = 0; dec_valid = 0;
      for (int r = 1; r <= NR; r++) begin
         if (r > 1) @(negedge clk);
         #1;
         chk({tag, " roundEn"}, dp_round_en, 1);
         chk({tag, " roundIdx"}, dp_round_idx, r);
         chk({tag, " key"}, dp_key_idx, expSrc ? NR - r : r);
         chk({tag, " last"}, dp_last, r == NR);
         chk({tag, " mode"}, dp_mode, expSrc);
         chk({tag, " rsp"}, rsp_valid, 0);
      end
      @(negedge clk);
      for (int h = 0; h < hold; h++) begin
         enc_valid = 1; dec_valid = 1;
         #1;
         chk({tag, " holdRsp"}, rsp_valid, 1);
         chk({tag, " holdSrc"}, rsp_src, expSrc);
         chk({tag, " holdRdy"}, {enc_ready, dec_ready}, 0);
         chk({tag, " holdDp"}, dpAll, 0);
         @(negedge clk);
      end
      enc_valid = 0; dec_valid = 0; rsp_ready = 1;
      #1;
      chk({tag, " rspValid"}, rsp_valid, 1);
      chk({tag, " rspSrc"}, rsp_src, expSrc);
      chk({tag, " doneDp"}, dpAll, 0);
      @(negedge clk);
      #1;
      chk({tag, " backIdle"}, busy, 0);
      chk({tag, " rspDrop"}, rsp_valid, 0);
   endtask

   initial begin
      logic seenRsp;
      logic expSrc;
      reset = 1; enc_valid = 1; dec_valid = 1; rsp_ready = 1;
      bEncValid = 0; bDecValid = 0; bRspReady = 1;

      // Reset state, with both valids high to catch leaking readies.
      @(negedge clk); #1;
      chk("rst rdy", {enc_ready, dec_ready}, 0);
      chk("rst busy", busy, 0);
      chk("rst rsp", {rsp_valid, rsp_src}, 0);
      chk("rst dp", dpAll, 0);
      enc_valid = 0; dec_valid = 0;
      @(negedge clk); reset = 0;

      doBlock("t1 enc", 1, 0, SRC_ENC, 0);
      doBlock("t2 dec", 0, 1, SRC_DEC, 0);

      // Fresh reset so the round-robin pointer starts on enc.
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef AES_SCHED_RR_EN
         expSrc = (i % 2 == 1);
`else
         expSrc = SRC_DEC;
`endif
         doBlock("t3 both", 1, 1, expSrc, 0);
      end

      doBlock("t4 bp", 1, 0, SRC_ENC, 20);
      doBlock("t4 after", 0, 1, SRC_DEC, 0);

      // Reset in the middle of round 5.
      @(negedge clk);
      enc_valid = 1; rsp_ready = 1;
      #1 chk("t5 accept", enc_ready, 1);
      for (int r = 1; r <= 5; r++) begin
         @(negedge clk);
         enc_valid = 0;
      end
      #1 chk("t5 atRound", dp_round_idx, 5);
      #2 reset = 1;
      #1;
      chk("t5 rstBusy", busy, 0);
      chk("t5 rstDp", dpAll, 0);
      chk("t5 rstRsp", rsp_valid, 0);
      @(negedge clk); reset = 0;
      seenRsp = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk); #1;
         if (rsp_valid) seenRsp = 1;
      end
      chk("t5 noRsp", seenRsp, 0);
      doBlock("t5 rerun", 1, 0, SRC_ENC, 0);

      // NR=14 instance: dec block, key 14..0, response at T+15.
      @(negedge clk);
      bDecValid = 1; bRspReady = 1;
      #1;
      chk("t6 decRdy", bDecReady, 1);
      chk("t6 loadKey", bKeyIdx, NRB);
      for (int r = 1; r <= NRB; r++) begin
         @(negedge clk);
         bDecValid = 0;
         #1;
         chk("t6 key", bKeyIdx, NRB - r);
         chk("t6 last", bLast, r == NRB);
         chk("t6 rspEarly", bRspValid, 0);
      end
      @(negedge clk); #1;
      chk("t6 rspValid", bRspValid, 1);
      chk("t6 rspSrc", bRspSrc, SRC_DEC);
      @(negedge clk); #1;
      chk("t6 idle", bBusy, 0);

      $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
      $finish;
   end

endmodule
